// File: rtl/video_sig_gen_if.sv
// rtl/video_sig_gen_if.sv - timing output bundle of video_sig_gen (counters, syncs, draw, frame strobe)
interface video_sig_gen_if #(
  parameter int HW = 10,
  parameter int VW = 10,
  parameter int FW = 6
);
  logic [HW-1:0] o_hcount;
  logic [VW-1:0] o_vcount;
  logic          o_hs;
  logic          o_vs;
  logic          o_ad;
  logic          o_nf;
  logic [FW-1:0] o_fc;

  modport master (output o_hcount, o_vcount, o_hs, o_vs, o_ad, o_nf, o_fc);
  modport slave  (input  o_hcount, o_vcount, o_hs, o_vs, o_ad, o_nf, o_fc);
endinterface

// File: rtl/video_sig_gen.sv
// rtl/video_sig_gen.sv - raster timing generator; frame counter compiled in by VIDEO_SIG_GEN_FRAME_COUNT_EN
// Flags are computed from the next counter values so every registered output describes the same pixel.
module video_sig_gen #(
  parameter int ACTIVE_H_PIXELS = 640,
  parameter int H_FRONT_PORCH   = 16,
  parameter int H_SYNC_WIDTH    = 96,
  parameter int H_BACK_PORCH    = 48,
  parameter int ACTIVE_LINES    = 480,
  parameter int V_FRONT_PORCH   = 10,
  parameter int V_SYNC_WIDTH    = 2,
  parameter int V_BACK_PORCH    = 33,
  parameter int FPS             = 60
) (
  input  logic            i_clk,
  input  logic            i_rst,
  video_sig_gen_if.master vid
);
  localparam int H_TOTAL = ACTIVE_H_PIXELS + H_FRONT_PORCH + H_SYNC_WIDTH + H_BACK_PORCH;
  localparam int V_TOTAL = ACTIVE_LINES + V_FRONT_PORCH + V_SYNC_WIDTH + V_BACK_PORCH;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int FW = (FPS > 1) ? $clog2(FPS) : 1;

  // Inclusive upper bounds keep every constant below the total, so nothing overflows the counter width.
  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_LAST = HW'(ACTIVE_H_PIXELS - 1);
  localparam logic [HW-1:0] HS_FIRST   = HW'(ACTIVE_H_PIXELS + H_FRONT_PORCH);
  localparam logic [HW-1:0] HS_LAST    = HW'(ACTIVE_H_PIXELS + H_FRONT_PORCH + H_SYNC_WIDTH - 1);
  localparam logic [HW-1:0] H_NF       = HW'(ACTIVE_H_PIXELS);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_LAST = VW'(ACTIVE_LINES - 1);
  localparam logic [VW-1:0] VS_FIRST   = VW'(ACTIVE_LINES + V_FRONT_PORCH);
  localparam logic [VW-1:0] VS_LAST    = VW'(ACTIVE_LINES + V_FRONT_PORCH + V_SYNC_WIDTH - 1);
  localparam logic [VW-1:0] V_NF       = VW'(ACTIVE_LINES);

  logic [HW-1:0] hcount_q, hcount_d;
  logic [VW-1:0] vcount_q, vcount_d;
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  logic          ad_q, ad_d;
  logic          nf_q, nf_d;

  always_comb begin
    hcount_d = (hcount_q == H_LAST) ? '0 : hcount_q + 1'b1;
    vcount_d = vcount_q;
    if (hcount_q == H_LAST) begin
      vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + 1'b1;
    end
    ad_d = (hcount_d <= H_ACT_LAST) && (vcount_d <= V_ACT_LAST);
    hs_d = (hcount_d >= HS_FIRST) && (hcount_d <= HS_LAST);
    vs_d = (vcount_d >= VS_FIRST) && (vcount_d <= VS_LAST);
    nf_d = (hcount_d == H_NF) && (vcount_d == V_NF);
  end

  // Reset parks the counters on the last pixel so the first free-running edge lands on (0,0).
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      hcount_q <= H_LAST;
      vcount_q <= V_LAST;
      hs_q     <= 1'b0;
      vs_q     <= 1'b0;
      ad_q     <= 1'b0;
      nf_q     <= 1'b0;
    end else begin
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      ad_q     <= ad_d;
      nf_q     <= nf_d;
    end
  end

`ifdef VIDEO_SIG_GEN_FRAME_COUNT_EN
  localparam logic [FW-1:0] FC_LAST = FW'(FPS - 1);

  logic [FW-1:0] fc_q, fc_d;

  always_comb begin
    fc_d = fc_q;
    if (nf_d) begin
      fc_d = (fc_q == FC_LAST) ? '0 : fc_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      fc_q <= '0;
    end else begin
      fc_q <= fc_d;
    end
  end

  assign vid.o_fc = fc_q;
`else
  assign vid.o_fc = '0;
`endif

  assign vid.o_hcount = hcount_q;
  assign vid.o_vcount = vcount_q;
  assign vid.o_hs     = hs_q;
  assign vid.o_vs     = vs_q;
  assign vid.o_ad     = ad_q;
  assign vid.o_nf     = nf_q;
endmodule
